wishbone_led_bank: RTL and testbench

WISHBONE_LED_BANK -- requirements
Module: wishbone_led_bank

---
 rtl/wishbone_led_bank.sv | 123 ++++++++++++
 tb/tb_wishbone_led_bank.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/wishbone_led_bank.sv
// Wishbone-attached LED bank: per-channel static/blink control driven by a shared prescaler.
// Single-cycle registered completions; blinking channels share one phase bit.
module wishbone_led_bank #(
  parameter int unsigned      NLEDS     = 8,
  parameter int unsigned      ADDR_W    = 3,
  parameter int unsigned      DIV_W     = 24,
  parameter logic [DIV_W-1:0] DIV_RESET = DIV_W'(24'd13_500_000),
  parameter logic [31:0]      ID_VALUE  = 32'h4C45_4401
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_wb_cyc,
  input  logic              i_wb_stb,
  input  logic              i_wb_we,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [31:0]       i_wb_idata,
  output logic              o_wb_ack,
  output logic              o_wb_stall,
  output logic              o_wb_err,
  output logic [31:0]       o_wb_odata,
  output logic [NLEDS-1:0]  o_led
);

  localparam logic [ADDR_W-1:0] ADDR_ID   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_OUT  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_MODE = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_DIV  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] ADDR_LIM  = ADDR_W'(4);

  logic [NLEDS-1:0] out_r, mode_r, led_r;
  logic [NLEDS-1:0] out_s, mode_s, led_s;
  logic [DIV_W-1:0] div_r, cnt_r, div_s, cnt_s;
  logic             phase_r, phase_s;
  logic             ack_r, err_r, ack_s, err_s;
  logic [31:0]      odata_r, odata_s, rdata_s;
  logic             accept_s, bad_s, wr_s;
  logic             unused_s;

  assign unused_s   = ^i_wb_idata;
  assign o_wb_stall = 1'b0;
  assign o_wb_ack   = ack_r;
  assign o_wb_err   = err_r;
  assign o_wb_odata = odata_r;
  assign o_led      = led_r;

  // Decode the bus request, compute next register state and next LED drive
  always_comb begin
    accept_s = i_wb_cyc & i_wb_stb;
    bad_s    = (i_wb_addr >= ADDR_LIM) | (i_wb_we & (i_wb_addr == ADDR_ID));
    wr_s     = accept_s & i_wb_we & ~bad_s;

    rdata_s = 32'd0;
    case (i_wb_addr)
      ADDR_ID:   rdata_s = ID_VALUE;
      ADDR_OUT:  rdata_s[NLEDS-1:0] = out_r;
      ADDR_MODE: rdata_s[NLEDS-1:0] = mode_r;
      ADDR_DIV:  rdata_s[DIV_W-1:0] = div_r;
      default:   rdata_s = 32'd0;
    endcase

    out_s  = out_r;
    mode_s = mode_r;
    div_s  = div_r;
    if (wr_s && (i_wb_addr == ADDR_OUT)) begin
      out_s = i_wb_idata[NLEDS-1:0];
    end else if (wr_s && (i_wb_addr == ADDR_MODE)) begin
      mode_s = i_wb_idata[NLEDS-1:0];
    end else if (wr_s && (i_wb_addr == ADDR_DIV)) begin
      div_s = i_wb_idata[DIV_W-1:0];
    end else begin
      div_s = div_r;
    end

    // A DIV write restarts the blink cycle and swallows any coincident tick
    if (wr_s && (i_wb_addr == ADDR_DIV)) begin
      cnt_s   = i_wb_idata[DIV_W-1:0];
      phase_s = 1'b0;
    end else if (cnt_r == {DIV_W{1'b0}}) begin
      cnt_s   = div_r;
      phase_s = ~phase_r;
    end else begin
      cnt_s   = cnt_r - DIV_W'(1);
      phase_s = phase_r;
    end

    // Built from next-state values so a write shows on the LEDs alongside its ack
    led_s = (mode_s & {NLEDS{phase_s}}) | (out_s & ~mode_s);

    ack_s   = accept_s & ~bad_s;
    err_s   = accept_s & bad_s;
    if (accept_s && !bad_s && !i_wb_we) begin
      odata_s = rdata_s;
    end else begin
      odata_s = 32'd0;
    end
  end

  // State, prescaler and registered bus/LED outputs
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      out_r   <= {NLEDS{1'b0}};
      mode_r  <= {NLEDS{1'b0}};
      div_r   <= DIV_RESET;
      cnt_r   <= DIV_RESET;
      phase_r <= 1'b0;
      led_r   <= {NLEDS{1'b0}};
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      odata_r <= 32'd0;
    end else begin
      out_r   <= out_s;
      mode_r  <= mode_s;
      div_r   <= div_s;
      cnt_r   <= cnt_s;
      phase_r <= phase_s;
      led_r   <= led_s;
      ack_r   <= ack_s;
      err_r   <= err_s;
      odata_r <= odata_s;
    end
  end

endmodule

// File: tb/tb_wishbone_led_bank.sv
// Randomized scoreboard bench for wishbone_led_bank against a register-map/timing reference model.
// The model predicts each completion and the LED pattern every cycle; a negedge monitor compares.
module tb_wishbone_led_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic [31:0] idata = 32'd0;
  logic        ack, stall, err;
  logic [31:0] odata;
  logic [7:0]  led;

  wishbone_led_bank dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_idata(idata),
    .o_wb_ack(ack), .o_wb_stall(stall), .o_wb_err(err),
    .o_wb_odata(odata), .o_led(led)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ack;
    bit          err;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_pass = 0;

  // reference model state
  logic [7:0]  m_out = 8'd0, m_mode = 8'd0;
  longint      m_div = 13_500_000;
  longint      m_since = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] model_led();
    bit ph;
    ph = ((m_since / (m_div + 1)) % 2) == 1;
    return (m_mode & {8{ph}}) | (m_out & ~m_mode);
  endfunction

  // Reference model: register map semantics, one predicted completion per accepted request
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out = 8'd0; m_mode = 8'd0; m_div = 13_500_000; m_since = 0;
      q.delete();
    end else begin
      exp_t e;
      m_since++;
      if (cyc && stb) begin
        if (addr >= 3'd4 || (we && addr == 3'd0)) begin
          e.ack = 1'b0; e.err = 1'b1; e.data = 32'd0;
        end else begin
          e.ack = 1'b1; e.err = 1'b0; e.data = 32'd0;
          if (!we) begin
            case (addr)
              3'd0: e.data = 32'h4C45_4401;
              3'd1: e.data = {24'd0, m_out};
              3'd2: e.data = {24'd0, m_mode};
              default: e.data = 32'(m_div);
            endcase
          end else begin
            case (addr)
              3'd1: m_out = idata[7:0];
              3'd2: m_mode = idata[7:0];
              default: begin m_div = longint'(idata[23:0]); m_since = 0; end
            endcase
          end
        end
        q.push_back(e);
      end
    end
  end

  // Monitor: pop and compare completions, check LEDs every cycle
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("stall", {31'd0, stall}, 32'd0);
      check("led", {24'd0, led}, {24'd0, model_led()});
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check("completion_present", {31'd0, ack | err}, 32'd1);
        check("ack", {31'd0, ack}, {31'd0, e.ack});
        check("err", {31'd0, err}, {31'd0, e.err});
        check("odata", odata, e.data);
      end else begin
        check("spurious_completion", {30'd0, ack, err}, 32'd0);
        check("idle_odata", odata, 32'd0);
      end
    end
  end

  task automatic bus(input bit w, input logic [2:0] a, input logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; idata = d;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc = 1'b0; stb = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #7;
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_odata", odata, 32'd0);
    check("rst_led", {24'd0, led}, 32'd0);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    bus(1'b1, 3'd1, 32'hFFFF_FF5A);
    bus(1'b0, 3'd1, 32'd0);
    idle(1);
    bus(1'b0, 3'd0, 32'd0);
    bus(1'b1, 3'd0, 32'd0);
    bus(1'b0, 3'd0, 32'd0);
    bus(1'b0, 3'd5, 32'd0);
    bus(1'b1, 3'd1, 32'd1);
    bus(1'b0, 3'd2, 32'd0);
    idle(2);

    bus(1'b1, 3'd3, 32'd3);
    bus(1'b1, 3'd2, 32'h01);
    bus(1'b1, 3'd1, 32'd0);
    idle(20);
    bus(1'b1, 3'd2, 32'h00);
    idle(3);
    bus(1'b1, 3'd3, 32'd0);
    bus(1'b1, 3'd2, 32'h03);
    idle(10);
    bus(1'b1, 3'd2, 32'h00);
    idle(2);

    for (int i = 0; i < 400; i++) begin
      logic [2:0]  a;
      logic [31:0] d;
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if (a == 3'd3) d = (d & 32'hFF00_0000) | 32'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) begin
        cyc = 1'($urandom_range(0, 1));
        stb = ~cyc;
        we = 1'($urandom_range(0, 1)); addr = a; idata = d;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
      end else begin
        bus(1'($urandom_range(0, 1)), a, d);
      end
    end

    bus(1'b1, 3'd2, 32'h00);
    bus(1'b1, 3'd1, 32'hFF);
    idle(1);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 3'd3; idata = 32'd0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_ack", {31'd0, ack}, 32'd0);
    check("async_rst_err", {31'd0, err}, 32'd0);
    check("async_rst_odata", odata, 32'd0);
    check("async_rst_led", {24'd0, led}, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    bus(1'b0, 3'd3, 32'd0);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
